// File: rtl/pc_redirect_unit.sv
// Fetch PC register with prioritised exception/ERET/branch redirects and a one-entry
// pending-branch slot for stalls. Define PC_HIST_EN to add a redirect-history ring.
module pc_redirect_unit #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'hbfc0_0000),
  parameter int unsigned      STEP       = 4,
  parameter int unsigned      HIST_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          stall,
  input  logic                          exc_req,
  input  logic [WIDTH-1:0]              exc_pc,
  input  logic                          eret_req,
  input  logic [WIDTH-1:0]              epc,
  input  logic                          br_req,
  input  logic [WIDTH-1:0]              br_target,
  output logic [WIDTH-1:0]              pc,
  output logic                          pend_valid,
  output logic                          adel,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
  output logic [WIDTH-1:0]              hist_rd_data
);

  localparam int unsigned IDXW = $clog2(HIST_DEPTH);

  logic [WIDTH-1:0] r_pc;
  logic             r_pend_valid;
  logic [WIDTH-1:0] r_pend_pc;

  logic             w_redir;
  logic [WIDTH-1:0] w_redir_pc;
  logic             w_buffer;
  logic [WIDTH-1:0] w_pc_nxt;
  logic             w_pend_valid_nxt;
  logic [WIDTH-1:0] w_pend_pc_nxt;

  // Select the redirect that actually lands on pc this edge, if any.
  always_comb begin
    w_redir    = 1'b0;
    w_redir_pc = '0;
    w_buffer   = 1'b0;
    if (exc_req) begin
      w_redir    = 1'b1;
      w_redir_pc = exc_pc;
    end else if (eret_req) begin
      w_redir    = 1'b1;
      w_redir_pc = epc;
    end else if (br_req && stall) begin
      w_buffer   = 1'b1;
    end else if (br_req) begin
      w_redir    = 1'b1;
      w_redir_pc = br_target;
    end else if (!stall && r_pend_valid) begin
      w_redir    = 1'b1;
      w_redir_pc = r_pend_pc;
    end
  end

  always_comb begin
    w_pc_nxt         = r_pc;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_pc_nxt    = r_pend_pc;
    if (w_redir) begin
      w_pc_nxt         = w_redir_pc;
      w_pend_valid_nxt = 1'b0;
    end else if (w_buffer) begin
      w_pend_valid_nxt = 1'b1;
      w_pend_pc_nxt    = br_target;
    end else if (!stall) begin
      w_pc_nxt = r_pc + WIDTH'(STEP);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
    end
  end

  assign pc         = r_pc;
  assign pend_valid = r_pend_valid;
  assign adel       = |r_pc[1:0];

`ifdef PC_HIST_EN
  logic [WIDTH-1:0] r_hist [HIST_DEPTH];
  logic [IDXW-1:0]  r_hist_wptr;
  logic [IDXW-1:0]  w_hist_rptr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
        r_hist[i] <= '0;
      end
      r_hist_wptr <= '0;
    end else if (w_redir) begin
      r_hist[r_hist_wptr] <= w_redir_pc;
      r_hist_wptr         <= r_hist_wptr + IDXW'(1);
    end
  end

  // wptr points at the next free slot, so the newest entry sits one behind it.
  assign w_hist_rptr  = r_hist_wptr - hist_rd_idx - IDXW'(1);
  assign hist_rd_data = r_hist[w_hist_rptr];
`else
  logic w_unused_hist_idx;
  assign w_unused_hist_idx = ^hist_rd_idx;
  assign hist_rd_data      = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0;
  logic        exc_req = 1'b0;
  logic [31:0] exc_pc = '0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = '0;
  logic        br_req = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] pc;
  logic        pend_valid;
  logic        adel;
  logic [1:0]  hist_rd_idx = '0;
  logic [31:0] hist_rd_data;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  pc_redirect_unit #(
    .WIDTH(32),
    .RESET_PC(32'hbfc0_0000),
    .STEP(4),
    .HIST_DEPTH(4)
  ) dut (
    .clk(clk), .resetn(resetn), .stall(stall),
    .exc_req(exc_req), .exc_pc(exc_pc),
    .eret_req(eret_req), .epc(epc),
    .br_req(br_req), .br_target(br_target),
    .pc(pc), .pend_valid(pend_valid), .adel(adel),
    .hist_rd_idx(hist_rd_idx), .hist_rd_data(hist_rd_data)
  );

  always #5 clk = ~clk;

  // Reference model: plain PC, one pending slot, and a list of recent redirect targets.
  logic [31:0] m_pc;
  bit          m_pend_v;
  logic [31:0] m_pend_pc;
  logic [31:0] m_hist[$];

  function automatic void m_apply(logic [31:0] t);
    m_pc     = t;
    m_pend_v = 1'b0;
    m_hist.push_front(t);
    void'(m_hist.pop_back());
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pc      = 32'hbfc0_0000;
      m_pend_v  = 1'b0;
      m_pend_pc = '0;
      m_hist    = {};
      for (int i = 0; i < 4; i++) m_hist.push_back(32'h0);
    end else if (exc_req) begin
      m_apply(exc_pc);
    end else if (eret_req) begin
      m_apply(epc);
    end else if (br_req) begin
      if (stall) begin
        m_pend_v  = 1'b1;
        m_pend_pc = br_target;
      end else begin
        m_apply(br_target);
      end
    end else if (!stall) begin
      if (m_pend_v) m_apply(m_pend_pc);
      else          m_pc = m_pc + 32'd4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_hist(input logic [1:0] idx);
`ifdef PC_HIST_EN
    return m_hist[idx];
`else
    return 32'h0;
`endif
  endfunction

  always @(negedge clk) begin
    if (run) begin
      check("cyc_pc", pc, m_pc);
      check("cyc_pend", {31'b0, pend_valid}, {31'b0, m_pend_v});
      check("cyc_adel", {31'b0, adel}, {31'b0, |m_pc[1:0]});
      check("cyc_hist", hist_rd_data, exp_hist(hist_rd_idx));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    hist_rd_idx = hist_rd_idx + 2'd1;
  endtask

  initial begin
    tick(); tick();
    run = 1'b1;
    check("rst_pc", pc, 32'hbfc0_0000);
    check("rst_pend", {31'b0, pend_valid}, 32'h0);

    // T1: sequential stepping after release
    resetn = 1'b1;
    tick(); check("t1_pc1", pc, 32'hbfc0_0004);
    tick(); check("t1_pc2", pc, 32'hbfc0_0008);
    tick(); check("t1_pc3", pc, 32'hbfc0_000c);

    // Branch buffered under stall, then reset mid-stall discards it
    stall = 1'b1; br_req = 1'b1; br_target = 32'h8000_0100;
    tick(); check("t2_pend_set", {31'b0, pend_valid}, 32'h1);
    check("t2_pc_hold", pc, 32'hbfc0_000c);
    br_req = 1'b0;
    tick(); check("t2_pc_hold2", pc, 32'hbfc0_000c);
    resetn = 1'b0;
    #1;
    check("rst_mid_pc", pc, 32'hbfc0_0000);
    check("rst_mid_pend", {31'b0, pend_valid}, 32'h0);
    tick();
    resetn = 1'b1; stall = 1'b0;
    tick(); check("rst_discard", pc, 32'hbfc0_0004);

    // T2: pending replay
    stall = 1'b1; br_req = 1'b1; br_target = 32'h8000_0100;
    tick();
    br_req = 1'b0; stall = 1'b0;
    tick(); check("t2_replay_pc", pc, 32'h8000_0100);
    check("t2_replay_pend", {31'b0, pend_valid}, 32'h0);

    // T3: priority exc > eret > br, with a pending entry present
    stall = 1'b1; br_req = 1'b1; br_target = 32'h1111_1110;
    tick();
    exc_req = 1'b1; exc_pc = 32'hbfc0_0380;
    eret_req = 1'b1; epc = 32'h8000_1000; br_target = 32'h8000_2000;
    tick(); check("t3_exc_pc", pc, 32'hbfc0_0380);
    check("t3_exc_pend", {31'b0, pend_valid}, 32'h0);
    exc_req = 1'b0; stall = 1'b0;
    tick(); check("t3_eret_pc", pc, 32'h8000_1000);
    eret_req = 1'b0; br_req = 1'b0;
    tick(); check("t3_step", pc, 32'h8000_1004);
    stall = 1'b1; br_req = 1'b1; br_target = 32'h8000_2000;
    tick();
    br_req = 1'b0; eret_req = 1'b1;
    tick(); check("t3_eret_stall", pc, 32'h8000_1000);
    check("t3_eret_clr", {31'b0, pend_valid}, 32'h0);
    eret_req = 1'b0;
    tick(); check("t3_hold", pc, 32'h8000_1000);
    stall = 1'b0;

    // T4: newer buffered target overwrites; live branch beats pending
    stall = 1'b1; br_req = 1'b1; br_target = 32'h8000_3000;
    tick();
    br_target = 32'h8000_4000;
    tick();
    br_req = 1'b0; stall = 1'b0;
    tick(); check("t4_overwrite", pc, 32'h8000_4000);
    stall = 1'b1; br_req = 1'b1; br_target = 32'h8000_3000;
    tick();
    stall = 1'b0; br_target = 32'h8000_5000;
    tick(); check("t4_newer_wins", pc, 32'h8000_5000);
    check("t4_pend_clr", {31'b0, pend_valid}, 32'h0);
    br_req = 1'b0;
    tick(); check("t4_no_replay", pc, 32'h8000_5004);

    // T5: wrap and misaligned target
    br_req = 1'b1; br_target = 32'hffff_fffc;
    tick();
    br_req = 1'b0;
    tick(); check("t5_wrap", pc, 32'h0000_0000);
    check("t5_adel0", {31'b0, adel}, 32'h0);
    br_req = 1'b1; br_target = 32'h8000_0102;
    tick(); check("t5_adel1", {31'b0, adel}, 32'h1);
    br_req = 1'b0;
    tick(); check("t5_mis_step", pc, 32'h8000_0106);

    // T6: five redirects R1..R5 into a 4-entry history
    br_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      br_target = 32'h9000_0000 + 32'(i * 16);
      tick();
    end
    br_req = 1'b0;
    hist_rd_idx = 2'd0;
    #1;
`ifdef PC_HIST_EN
    check("t6_idx0", hist_rd_data, 32'h9000_0050);
`else
    check("t6_idx0", hist_rd_data, 32'h0);
`endif
    hist_rd_idx = 2'd3;
    #1;
`ifdef PC_HIST_EN
    check("t6_idx3", hist_rd_data, 32'h9000_0020);
`else
    check("t6_idx3", hist_rd_data, 32'h0);
`endif
    tick(); tick(); tick(); tick();

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
